// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Operands are registered into the ALU, the result is registered out of it.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [4:0]            req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [4:0]            req1_ctrl,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_eq,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_eq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_r;
  logic                  prio_r;
  logic                  grant_r;
  logic [DATA_WIDTH-1:0] op1_r;
  logic [DATA_WIDTH-1:0] op2_r;
  logic [4:0]            ctrl_r;
  logic [DATA_WIDTH-1:0] res_r;
  logic                  eq_r;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;

  logic any_s;
  logic win_s;
  logic req0_ready_s;
  logic req1_ready_s;
  logic rsp_hs_s;

  // Arbitration, accept handshake and response handshake decode
  always_comb begin
    any_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_s = prio_r;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    // rst_n gating keeps ready low while reset is held, even with IDLE decoded
    if ((state_r == IDLE) && rst_n) begin
      req0_ready_s = req0_valid & ~win_s;
      req1_ready_s = req1_valid & win_s;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
    if (grant_r) begin
      rsp_hs_s = rsp1_valid_r & rsp1_ready;
    end else begin
      rsp_hs_s = rsp0_valid_r & rsp0_ready;
    end
  end

  // Control FSM with operand, result and response-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      prio_r       <= 1'b0;
      grant_r      <= 1'b0;
      op1_r        <= {DATA_WIDTH{1'b0}};
      op2_r        <= {DATA_WIDTH{1'b0}};
      ctrl_r       <= 5'd0;
      res_r        <= {DATA_WIDTH{1'b0}};
      eq_r         <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r <= win_s;
            op1_r   <= win_s ? req1_op1  : req0_op1;
            op2_r   <= win_s ? req1_op2  : req0_op2;
            ctrl_r  <= win_s ? req1_ctrl : req0_ctrl;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_r        <= alu_out;
          eq_r         <= alu_eq;
          rsp0_valid_r <= ~grant_r;
          rsp1_valid_r <= grant_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            prio_r       <= ~grant_r;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign alu_op1    = op1_r;
  assign alu_op2    = op2_r;
  assign alu_ctrl   = ctrl_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = res_r;
  assign rsp1_data  = res_r;
  assign rsp0_eq    = eq_r;
  assign rsp1_eq    = eq_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter with an external ALU model
// and a transaction-level reference (round-robin owner, ALU arithmetic).
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [4:0]  alu_ctrl;
  logic        alu_eq;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_eq, rsp1_eq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tb_prio = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_eq(alu_eq),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_eq(rsp0_eq),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_eq(rsp1_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] c);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU stand-in: EQ compares the two operands
  always_comb begin
    alu_out = alu_ref(alu_op1, alu_op2, alu_ctrl);
    alu_eq  = (alu_op1 == alu_op2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int p);
    return (p == 1) ? 32'd2 : 32'd1;
  endfunction

  // One isolated request on port p, response held off for 'hold' cycles
  task automatic run_single(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] c, input int hold, input bit poke);
    logic [31:0] ed;
    logic        ee;
    ed = alu_ref(a, b, c);
    ee = (a == b);
    if (p == 1) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    end
    #1;
    chk("accept_ready", {30'd0, req1_ready, req0_ready}, onehot(p));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("exec_alu_op1", alu_op1, a);
    chk("exec_alu_op2", alu_op2, b);
    chk("exec_alu_ctrl", {27'd0, alu_ctrl}, {27'd0, c});
    tick();
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        if (p == 1) begin
          req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_ctrl = 5'd0;
        end else begin
          req1_valid = 1'b1; req1_op1 = 32'd1; req1_op2 = 32'd2; req1_ctrl = 5'd0;
        end
      end
      #1;
      chk("hold_valid", {30'd0, rsp1_valid, rsp0_valid}, onehot(p));
      chk("hold_data", (p == 1) ? rsp1_data : rsp0_data, ed);
      chk("hold_eq", {31'd0, (p == 1) ? rsp1_eq : rsp0_eq}, {31'd0, ee});
      chk("hold_no_accept", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    if (p == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    #1;
    chk("resp_valid", {30'd0, rsp1_valid, rsp0_valid}, onehot(p));
    chk("resp_data", (p == 1) ? rsp1_data : rsp0_data, ed);
    chk("resp_eq", {31'd0, (p == 1) ? rsp1_eq : rsp0_eq}, {31'd0, ee});
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("post_valid_low", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("post_data_held", (p == 1) ? rsp1_data : rsp0_data, ed);
    tb_prio = (p == 1) ? 0 : 1;
  endtask

  initial begin
    logic [31:0] ea, eb, ed;
    logic [4:0]  ec;
    int          w;
    int          last;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = 32'd0; req0_op2 = 32'd0; req0_ctrl = 5'd0;
    req1_op1 = 32'd0; req1_op2 = 32'd0; req1_ctrl = 5'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", rsp0_data, 32'd0);
    rst_n = 1'b1;
    tick();

    run_single(0, 32'd5, 32'd7, 5'd0, 0, 1'b0);
    run_single(1, 32'd9, 32'd9, 5'd1, 4, 1'b1);

    // Both requesters always valid: grants alternate, one response per 3 cycles
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd6; req0_ctrl = 5'd2;
    req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd4; req1_ctrl = 5'd3;
    last = 0;
    for (int k = 0; k < 10; k++) begin
      w = tb_prio;
      #1;
      chk("rr_ready", {30'd0, req1_ready, req0_ready}, onehot(w));
      ea = (w == 1) ? req1_op1 : req0_op1;
      eb = (w == 1) ? req1_op2 : req0_op2;
      ec = (w == 1) ? req1_ctrl : req0_ctrl;
      ed = alu_ref(ea, eb, ec);
      tick();
      if (w == 1) begin
        req1_op1 = $urandom; req1_op2 = ($urandom_range(0, 3) == 0) ? req1_op1 : $urandom;
        req1_ctrl = 5'($urandom_range(0, 7));
      end else begin
        req0_op1 = $urandom; req0_op2 = ($urandom_range(0, 3) == 0) ? req0_op1 : $urandom;
        req0_ctrl = 5'($urandom_range(0, 7));
      end
      #1;
      chk("rr_exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      tick();
      #1;
      chk("rr_rsp_port", {30'd0, rsp1_valid, rsp0_valid}, onehot(w));
      chk("rr_rsp_data", (w == 1) ? rsp1_data : rsp0_data, ed);
      chk("rr_rsp_eq", {31'd0, (w == 1) ? rsp1_eq : rsp0_eq}, {31'd0, ea == eb});
      if (k > 0) chk("rr_period", cyc - last, 32'd3);
      last = cyc;
      tick();
      tb_prio = (w == 1) ? 0 : 1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    if (tb_prio == 1) begin
      run_single(1, 32'd5, 32'd5, 5'd7, 0, 1'b0);
    end else begin
      run_single(0, 32'd5, 32'd5, 5'd7, 0, 1'b0);
    end

    run_single(1, 32'd5, 32'd5, 5'd7, 0, 1'b0);
    run_single(0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 1'b0);

    // Reset while EXEC: op discarded, priority returns to requester 0
    req0_valid = 1'b1; req0_op1 = 32'd11; req0_op2 = 32'd22; req0_ctrl = 5'd1;
    #1;
    chk("pre_rst_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_op1", alu_op1, 32'd0);
    chk("midrst_alu_op2", alu_op2, 32'd0);
    chk("midrst_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
    chk("midrst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("midrst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("postrst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("postrst_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
